// File: rtl/wave_pkg.sv
// Shared types and constants for the WAV capture block: FSM states,
// RIFF/WAVE header layout and fourCC words (byte 0 in the LSB).
package wave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_FIXUP
  } state_t;

  localparam int unsigned HDR_LEN  = 44;
  localparam int unsigned RIFF_OFS = 4;
  localparam int unsigned SIZE_OFS = 40;

  localparam logic [31:0] FOURCC_RIFF = 32'h4646_4952;
  localparam logic [31:0] FOURCC_WAVE = 32'h4556_4157;
  localparam logic [31:0] FOURCC_FMT  = 32'h2074_6d66;
  localparam logic [31:0] FOURCC_DATA = 32'h6174_6164;

  // Fixup step k (0..7) maps to header bytes 4..7 then 40..43
  function automatic logic [5:0] fixup_index(input logic [5:0] k);
    return (k < 6'd4) ? 6'(RIFF_OFS) + k : 6'(SIZE_OFS) - 6'd4 + k;
  endfunction

endpackage

// File: rtl/wave_capture_if.sv
// Byte-wide memory write port of wave_capture (valid/ready style).
interface wave_capture_if;
  logic        O_WR_EN;
  logic [16:0] O_WR_ADDR;
  logic [7:0]  O_WR_DATA;
  logic        I_WR_RDY;

  modport master (output O_WR_EN, O_WR_ADDR, O_WR_DATA, input I_WR_RDY);
  modport slave  (input O_WR_EN, O_WR_ADDR, O_WR_DATA, output I_WR_RDY);
endinterface

// File: rtl/wave_hdr_gen.sv
// Combinational 44-byte mono 16-bit PCM WAV header: byte index + sizes -> byte.
module wave_hdr_gen
  import wave_pkg::*;
#(
  parameter int unsigned SAMPLE_RATE = 44100
) (
  input  logic [5:0]  idx,
  input  logic [31:0] data_size,
  input  logic        sizes_valid,
  output logic [7:0]  hdr_byte
);

  logic [31:0] hdr_word;
  logic [31:0] dsz;
  logic [31:0] riff;

  always_comb begin
    dsz  = sizes_valid ? data_size : '0;
    riff = sizes_valid ? data_size + 32'd36 : '0;
    case (idx[5:2])
      4'd0:    hdr_word = FOURCC_RIFF;
      4'd1:    hdr_word = riff;
      4'd2:    hdr_word = FOURCC_WAVE;
      4'd3:    hdr_word = FOURCC_FMT;
      4'd4:    hdr_word = 32'd16;
      4'd5:    hdr_word = 32'h0001_0001;
      4'd6:    hdr_word = 32'(SAMPLE_RATE);
      4'd7:    hdr_word = 32'(2 * SAMPLE_RATE);
      4'd8:    hdr_word = 32'h0010_0002;
      4'd9:    hdr_word = FOURCC_DATA;
      4'd10:   hdr_word = dsz;
      default: hdr_word = '0;
    endcase
    hdr_byte = hdr_word[{idx[1:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/wave_capture.sv
// Streams a WAV header followed by 16-bit PCM samples to byte memory.
// Define WAVE_CAPTURE_FIXUP_EN to write zero sizes first and patch them at the end.
module wave_capture
  import wave_pkg::*;
#(
  parameter int unsigned SAMPLE_RATE = 44100
) (
  input  logic                I_CLK,
  input  logic                I_RSTn,
  input  logic                I_START,
  input  logic                I_STOP,
  input  logic [16:0]         I_BASE_ADDR,
  input  logic [15:0]         I_MAX_LEN,
  input  logic                I_SAMPLE_STB,
  input  logic signed [15:0]  I_SAMPLE,
  wave_capture_if.master      wr,
  output logic                O_BUSY,
  output logic                O_DONE,
  output logic                O_OVERRUN,
  output logic [31:0]         O_DATA_SIZE
);

  state_t      state_q, state_n;
  logic        start_q;
  logic        stop_q, stop_n;
  logic [5:0]  idx_q, idx_n;
  logic [16:0] base_q, base_n;
  logic [15:0] max_q, max_n;
  logic [15:0] hold_q, hold_n;
  logic [1:0]  pend_q, pend_n;
  logic        wr_en_q, wr_en_n;
  logic [16:0] addr_q, addr_n;
  logic [7:0]  data_q, data_n;
  logic [31:0] size_q, size_n;
  logic        ovr_q, ovr_n;
  logic        done_q, done_n;

  logic        acc, start_edge, finish;
  logic [1:0]  pend_after;
  logic [31:0] size_acc;
  logic [16:0] data_addr;
  logic [5:0]  gen_idx;
  logic [31:0] gen_size;
  logic        gen_valid;
  logic [7:0]  gen_byte;

  assign acc        = wr_en_q & wr.I_WR_RDY;
  assign start_edge = I_START & ~start_q;
  assign pend_after = pend_q - {1'b0, acc};
  assign size_acc   = size_q + 32'(acc && (state_q == ST_DATA));
  assign data_addr  = base_q + 17'(HDR_LEN) + size_acc[16:0];

  // Generator is fed with next-cycle values so the byte is registered with its address
  always_comb begin
    case (state_q)
      ST_HDR:   gen_idx = idx_q;
      ST_DATA:  gen_idx = 6'(RIFF_OFS);
      ST_FIXUP: gen_idx = fixup_index(idx_q);
      default:  gen_idx = '0;
    endcase
`ifdef WAVE_CAPTURE_FIXUP_EN
    gen_size  = size_acc;
    gen_valid = (state_q == ST_DATA) || (state_q == ST_FIXUP);
`else
    gen_size  = {16'b0, (state_q == ST_IDLE) ? {I_MAX_LEN[15:1], 1'b0} : max_q};
    gen_valid = 1'b1;
`endif
  end

  wave_hdr_gen #(.SAMPLE_RATE(SAMPLE_RATE)) u_hdr_gen (
    .idx         (gen_idx),
    .data_size   (gen_size),
    .sizes_valid (gen_valid),
    .hdr_byte    (gen_byte)
  );

  always_comb begin
    state_n = state_q;
    stop_n  = stop_q;
    idx_n   = idx_q;
    base_n  = base_q;
    max_n   = max_q;
    hold_n  = hold_q;
    pend_n  = pend_q;
    wr_en_n = wr_en_q;
    addr_n  = addr_q;
    data_n  = data_q;
    size_n  = size_q;
    ovr_n   = ovr_q;
    done_n  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: if (start_edge) begin
        state_n = ST_HDR;
        stop_n  = 1'b0;
        size_n  = '0;
        ovr_n   = 1'b0;
        base_n  = I_BASE_ADDR;
        max_n   = {I_MAX_LEN[15:1], 1'b0};
        pend_n  = '0;
        idx_n   = 6'd1;
        wr_en_n = 1'b1;
        addr_n  = I_BASE_ADDR;
        data_n  = gen_byte;
      end
      ST_HDR: begin
        if (I_STOP) stop_n = 1'b1;
        if (acc) begin
          if (idx_q == 6'(HDR_LEN)) begin
            state_n = ST_DATA;
            wr_en_n = 1'b0;
          end else begin
            idx_n  = idx_q + 6'd1;
            addr_n = base_q + 17'(idx_q);
            data_n = gen_byte;
          end
        end
      end
      ST_DATA: begin
        size_n = size_acc;
        pend_n = pend_after;
        if (pend_after != 2'd0) begin
          if (acc) begin
            addr_n = data_addr;
            data_n = hold_q[15:8];
          end
          if (I_SAMPLE_STB) ovr_n = 1'b1;
        end else begin
          // Holding register frees up this cycle: a coincident strobe is captured
          wr_en_n = 1'b0;
          if (size_acc == {16'b0, max_q}) begin
            finish = 1'b1;
          end else if (I_SAMPLE_STB) begin
            hold_n  = I_SAMPLE;
            pend_n  = 2'd2;
            wr_en_n = 1'b1;
            addr_n  = data_addr;
            data_n  = I_SAMPLE[7:0];
          end else if (I_STOP || stop_q) begin
            finish = 1'b1;
          end
        end
        if (finish) begin
`ifdef WAVE_CAPTURE_FIXUP_EN
          state_n = ST_FIXUP;
          idx_n   = 6'd1;
          wr_en_n = 1'b1;
          addr_n  = base_q + 17'(RIFF_OFS);
          data_n  = gen_byte;
`else
          state_n = ST_IDLE;
          done_n  = 1'b1;
`endif
        end
      end
      ST_FIXUP: if (acc) begin
        if (idx_q == 6'd8) begin
          state_n = ST_IDLE;
          wr_en_n = 1'b0;
          done_n  = 1'b1;
        end else begin
          idx_n  = idx_q + 6'd1;
          addr_n = base_q + 17'(gen_idx);
          data_n = gen_byte;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      idx_q   <= '0;
      base_q  <= '0;
      max_q   <= '0;
      hold_q  <= '0;
      pend_q  <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      start_q <= I_START;
      stop_q  <= stop_n;
      idx_q   <= idx_n;
      base_q  <= base_n;
      max_q   <= max_n;
      hold_q  <= hold_n;
      pend_q  <= pend_n;
      wr_en_q <= wr_en_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      size_q  <= size_n;
      ovr_q   <= ovr_n;
      done_q  <= done_n;
    end
  end

  assign wr.O_WR_EN   = wr_en_q;
  assign wr.O_WR_ADDR = addr_q;
  assign wr.O_WR_DATA = data_q;
  assign O_BUSY       = (state_q != ST_IDLE);
  assign O_DONE       = done_q;
  assign O_OVERRUN    = ovr_q;
  assign O_DATA_SIZE  = size_q;

endmodule
